// File: rtl/hdc_search_pkg.sv
// Shared configuration for the class hypervector search block.
// Holds the default geometry of the class ROM (frame width, frames per
// hypervector, class count), the index and distance widths derived from it,
// and the search FSM state encoding.
package hdc_search_pkg;

  localparam int FRAME_W     = 64;
  localparam int NUM_FRAMES  = 3;
  localparam int NUM_CLASSES = 8;
  localparam int CLASS_ID_W  = 3;
  localparam int FRAME_IDX_W = 2;
  localparam int DIST_W      = 8;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/hvec_popcount.sv
// Combinational population count of one hypervector frame.
// Ports:
//   vec  in   FRAME_W  frame to count
//   cnt  out  CNT_W    number of set bits in vec
module hvec_popcount #(
  parameter int FRAME_W = 64,
  parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
  input  logic [FRAME_W-1:0] vec,
  output logic [CNT_W-1:0]   cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/class_hvec_search.sv
// Associative-search reader for the class hypervector ROM.
// Buffers one query hypervector (NUM_FRAMES frames, frame 0 first), then
// walks every class/frame pair of the ROM, one pair per cycle, summing the
// per-frame Hamming distance. The class with the smallest total distance
// (ties go to the lower class id) is returned through a valid/ready port.
//
// Optional build macro HVEC_SEARCH_EARLY_ABORT_EN: a class is abandoned as
// soon as its partial distance reaches the current minimum, shortening the
// search without changing the result.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   query_frame_in  query frame data       (with query_valid / query_ready)
//   frame_id        class select to ROM    (0 outside the search)
//   frame_index     frame select to ROM    (0 outside the search)
//   class_vec_in    ROM data, combinational from frame_id/frame_index
//   pred_valid      result valid           (with pred_ready)
//   pred_class      winning class id
//   pred_dist       Hamming distance of the winning class
module class_hvec_search
  import hdc_search_pkg::*;
#(
  parameter int FRAME_W     = hdc_search_pkg::FRAME_W,
  parameter int NUM_FRAMES  = hdc_search_pkg::NUM_FRAMES,
  parameter int NUM_CLASSES = hdc_search_pkg::NUM_CLASSES,
  parameter int CLASS_ID_W  = hdc_search_pkg::CLASS_ID_W,
  parameter int FRAME_IDX_W = hdc_search_pkg::FRAME_IDX_W,
  parameter int DIST_W      = hdc_search_pkg::DIST_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_W-1:0]     query_frame_in,
  input  logic                   query_valid,
  output logic                   query_ready,
  output logic [CLASS_ID_W-1:0]  frame_id,
  output logic [FRAME_IDX_W-1:0] frame_index,
  input  logic [FRAME_W-1:0]     class_vec_in,
  output logic                   pred_valid,
  input  logic                   pred_ready,
  output logic [CLASS_ID_W-1:0]  pred_class,
  output logic [DIST_W-1:0]      pred_dist
);

  localparam int POP_W = $clog2(FRAME_W + 1);
  localparam logic [FRAME_IDX_W-1:0] LAST_FRM = FRAME_IDX_W'(NUM_FRAMES - 1);
  localparam logic [CLASS_ID_W-1:0]  LAST_CLS = CLASS_ID_W'(NUM_CLASSES - 1);

  state_t                 state, state_n;
  logic [FRAME_IDX_W-1:0] load_idx;
  logic [FRAME_IDX_W-1:0] frm;
  logic [CLASS_ID_W-1:0]  cls;
  logic [CLASS_ID_W-1:0]  best;
  logic [DIST_W-1:0]      acc;
  logic [DIST_W-1:0]      acc_n;
  logic [DIST_W-1:0]      min_dist;
  logic [FRAME_W-1:0]     query_buf [NUM_FRAMES];
  logic [POP_W-1:0]       pop;

  logic load_hs;
  logic pred_hs;
  logic in_search;
  logic last_frm;
  logic abort;
  logic class_end;
  logic class_win;

  hvec_popcount #(
    .FRAME_W (FRAME_W),
    .CNT_W   (POP_W)
  ) u_popcount (
    .vec (query_buf[frm] ^ class_vec_in),
    .cnt (pop)
  );

  // Popcount of one frame cannot exceed FRAME_W, and the full sum stays below
  // 2**DIST_W-1, so the accumulator never wraps.
  assign acc_n = acc + {{(DIST_W - POP_W){1'b0}}, pop};

  always_comb begin
    state_n     = state;
    query_ready = (state == S_LOAD) && !rst;
    pred_valid  = (state == S_DONE);
    in_search   = (state == S_SEARCH);
    frame_id    = in_search ? cls : '0;
    frame_index = in_search ? frm : '0;
    pred_class  = pred_valid ? best : '0;
    pred_dist   = pred_valid ? min_dist : '0;
    load_hs     = query_valid && query_ready;
    pred_hs     = pred_valid && pred_ready;
    last_frm    = (frm == LAST_FRM);
`ifdef HVEC_SEARCH_EARLY_ABORT_EN
    // A partial sum already at the minimum can only tie or lose, and ties
    // keep the earlier class, so the rest of this class is irrelevant.
    abort       = in_search && !last_frm && (acc_n >= min_dist);
`else
    abort       = 1'b0;
`endif
    class_end   = in_search && (last_frm || abort);
    class_win   = in_search && last_frm && (acc_n < min_dist);

    case (state)
      S_LOAD:   if (load_hs && (load_idx == LAST_FRM)) state_n = S_SEARCH;
      S_SEARCH: if (class_end && (cls == LAST_CLS))    state_n = S_DONE;
      S_DONE:   if (pred_hs)                           state_n = S_LOAD;
      default:  state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_idx <= '0;
      cls      <= '0;
      frm      <= '0;
      acc      <= '0;
      best     <= '0;
      min_dist <= '1;
    end else begin
      if (load_hs) begin
        load_idx <= (load_idx == LAST_FRM) ? '0 : load_idx + FRAME_IDX_W'(1);
      end
      if (in_search) begin
        if (class_end) begin
          acc <= '0;
          frm <= '0;
          // cls wraps to 0 after the last class, ready for the next query.
          cls <= (cls == LAST_CLS) ? '0 : cls + CLASS_ID_W'(1);
          if (class_win) begin
            min_dist <= acc_n;
            best     <= cls;
          end
        end else begin
          acc <= acc_n;
          frm <= frm + FRAME_IDX_W'(1);
        end
      end
      if (pred_hs) begin
        load_idx <= '0;
        min_dist <= '1;
      end
    end
  end

  // Query frame storage: pure data, overwritten on every load.
  always_ff @(posedge clk) begin
    if (load_hs) query_buf[load_idx] <= query_frame_in;
  end

endmodule

// File: tb/tb_class_hvec_search.sv
module tb_class_hvec_search;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] query_frame_in;
  logic        query_valid;
  logic        query_ready;
  logic [2:0]  frame_id;
  logic [1:0]  frame_index;
  logic [63:0] class_vec_in;
  logic        pred_valid;
  logic        pred_ready;
  logic [2:0]  pred_class;
  logic [7:0]  pred_dist;

  int compared   = 0;
  int mismatched = 0;
  int rom_mode   = 0;

  always #5 clk = ~clk;

  class_hvec_search dut (
    .clk            (clk),
    .rst            (rst),
    .query_frame_in (query_frame_in),
    .query_valid    (query_valid),
    .query_ready    (query_ready),
    .frame_id       (frame_id),
    .frame_index    (frame_index),
    .class_vec_in   (class_vec_in),
    .pred_valid     (pred_valid),
    .pred_ready     (pred_ready),
    .pred_class     (pred_class),
    .pred_dist      (pred_dist)
  );

  // Stand-in for the class ROM: a fixed hash pattern per class/frame.
  function automatic logic [63:0] real_rom(input int c, input int f);
    logic [31:0] a, b;
    a = 32'h9E3779B9 * 32'(c * 3 + f + 1);
    b = 32'hC2B2AE35 * 32'(c * 7 + f * 13 + 5);
    return {a, b ^ {a[24:0], 7'b0}};
  endfunction

  function automatic logic [63:0] rom_word(input int mode, input int c, input int f);
    case (mode)
      1:       return 64'h0000_0000_0000_F0F0;                  // 8 ones, all classes alike
      2:       return (f == 0) ? ((64'h1 << (c + 1)) - 64'h1) : 64'h0;
      3:       return (f == 0 && c != 7) ? ((64'h1 << (c + 1)) - 64'h1) : 64'h0;
      default: return real_rom(c, f);
    endcase
  endfunction

  always_comb class_vec_in = rom_word(rom_mode, int'(frame_id), int'(frame_index));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference search over the ROM model: plain sum of $countones per class.
  task automatic model(input logic [63:0] q0, q1, q2, output int bc, output int bd);
    int d;
    bd = 1000;
    bc = 0;
    for (int c = 0; c < 8; c++) begin
      d = $countones(q0 ^ rom_word(rom_mode, c, 0)) + $countones(q1 ^ rom_word(rom_mode, c, 1))
        + $countones(q2 ^ rom_word(rom_mode, c, 2));
      if (d < bd) begin
        bd = d;
        bc = c;
      end
    end
  endtask

  task automatic load_frames(input logic [63:0] q0, q1, q2);
    logic [63:0] q [3];
    q[0] = q0; q[1] = q1; q[2] = q2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("load_ready", 64'(query_ready), 64'd1);
      query_frame_in = q[i];
      query_valid    = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    query_valid    = 1'b0;
    query_frame_in = 64'h0;
  endtask

  // Loads a query and waits for pred_valid; lat = edges after the last load edge.
  task automatic run_query(input logic [63:0] q0, q1, q2, output int lat);
    load_frames(q0, q1, q2);
    check("fid_first", 64'(frame_id), 64'd0);
    check("fidx_first", 64'(frame_index), 64'd0);
    check("qready_search", 64'(query_ready), 64'd0);
    lat = 0;
    while (!pred_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) check("fidx_second", 64'(frame_index), 64'd1);
    end
    check("pred_valid_rise", 64'(pred_valid), 64'd1);
  endtask

  task automatic check_latency(input string tag, input int lat);
`ifdef HVEC_SEARCH_EARLY_ABORT_EN
    check(tag, 64'(lat <= 24), 64'd1);
`else
    check(tag, 64'(lat), 64'd24);
`endif
  endtask

  task automatic consume();
    @(negedge clk);
    pred_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pred_ready = 1'b0;
    check("after_pop_valid", 64'(pred_valid), 64'd0);
    check("after_pop_qready", 64'(query_ready), 64'd1);
  endtask

  initial begin
    int lat, ec, ed, c;
    logic [63:0] q0, q1, q2;

    rst            = 1'b1;
    query_valid    = 1'b0;
    query_frame_in = 64'h0;
    pred_ready     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_qready", 64'(query_ready), 64'd0);
    check("rst_pvalid", 64'(pred_valid), 64'd0);
    check("rst_fid", 64'(frame_id), 64'd0);
    check("rst_pdist", 64'(pred_dist), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_release_qready", 64'(query_ready), 64'd1);

    // Exact match on class 5.
    rom_mode = 0;
    run_query(real_rom(5, 0), real_rom(5, 1), real_rom(5, 2), lat);
    check("t1_class", 64'(pred_class), 64'd5);
    check("t1_dist", 64'(pred_dist), 64'd0);
    check_latency("t1_latency", lat);
`ifdef HVEC_SEARCH_EARLY_ABORT_EN
    check("t1_abort_shorter", 64'(lat < 24), 64'd1);
`endif

    // Result held while the sink stalls; query_valid ignored meanwhile.
    query_valid    = 1'b1;
    query_frame_in = 64'hFFFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(pred_valid), 64'd1);
      check("hold_class", 64'(pred_class), 64'd5);
      check("hold_dist", 64'(pred_dist), 64'd0);
      check("hold_qready", 64'(query_ready), 64'd0);
    end
    query_valid    = 1'b0;
    query_frame_in = 64'h0;
    consume();

    // All classes identical: tie resolves to class 0, distance 3*8.
    rom_mode = 1;
    run_query(64'h0, 64'h0, 64'h0, lat);
    check("t2_class", 64'(pred_class), 64'd0);
    check("t2_dist", 64'(pred_dist), 64'd24);
    check_latency("t2_latency", lat);
    consume();

    // Class k has k+1 ones: class 0 wins with distance 1.
    rom_mode = 2;
    run_query(64'h0, 64'h0, 64'h0, lat);
    check("t3a_class", 64'(pred_class), 64'd0);
    check("t3a_dist", 64'(pred_dist), 64'd1);
    consume();

    // Class 7 empty wins; pred_ready held high from before the search.
    rom_mode   = 3;
    pred_ready = 1'b1;
    run_query(64'h0, 64'h0, 64'h0, lat);
    check("t3b_class", 64'(pred_class), 64'd7);
    check("t3b_dist", 64'(pred_dist), 64'd0);
    check_latency("t3b_latency", lat);
    @(negedge clk);
    pred_ready = 1'b0;
    check("t3b_popped", 64'(pred_valid), 64'd0);
    check("t3b_qready", 64'(query_ready), 64'd1);

    // Reset in the middle of a search, then repeat the class 5 query.
    rom_mode = 0;
    load_frames(real_rom(5, 0), real_rom(5, 1), real_rom(5, 2));
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_qready_in_rst", 64'(query_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("t5_fid", 64'(frame_id), 64'd0);
    check("t5_fidx", 64'(frame_index), 64'd0);
    check("t5_pvalid", 64'(pred_valid), 64'd0);
    check("t5_pclass", 64'(pred_class), 64'd0);
    check("t5_pdist", 64'(pred_dist), 64'd0);
    check("t5_qready", 64'(query_ready), 64'd0);
    rst = 1'b0;
    run_query(real_rom(5, 0), real_rom(5, 1), real_rom(5, 2), lat);
    check("t5_class", 64'(pred_class), 64'd5);
    check("t5_dist", 64'(pred_dist), 64'd0);
    check_latency("t5_latency", lat);
    consume();

    // Noisy copies of ROM classes against the reference search.
    for (int n = 0; n < 6; n++) begin
      c  = $urandom_range(0, 7);
      q0 = real_rom(c, 0) ^ {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      q1 = real_rom(c, 1) ^ {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      q2 = real_rom(c, 2) ^ {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      model(q0, q1, q2, ec, ed);
      run_query(q0, q1, q2, lat);
      check("rand_class", 64'(pred_class), 64'(ec));
      check("rand_dist", 64'(pred_dist), 64'(ed));
      check_latency("rand_latency", lat);
      consume();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
